regfile_scoreboard: RTL and testbench

Parametrised successor to the single-write, dual-read register file used in the RISC-V datapath. It adds configurable width and depth, a hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard. The scoreboard lets the issue stage detect RAW and WAW hazards and stall. It sits between decode/issue, which supplies reads and issue requests, and writeback, which supplies writes.

---
 rtl/regfile_scoreboard.sv | 93 +++++++++
 tb/tb_regfile_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired-zero r0, optional write-to-read forwarding,
// and a per-register busy scoreboard that the issue stage uses to detect RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   RS1,
    input  logic [AW-1:0]   RS2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    input  logic [AW-1:0]   RD,
    input  logic [XLEN-1:0] WriteData,
    input  logic            RegWrite,
    input  logic            IssueValid,
    input  logic [AW-1:0]   IssueRD,
    input  logic            IssueUsesRD,
    output logic            IssueReady,
    output logic            Stall,
    output logic [NREG-1:0] Busy
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_d;
    logic [NREG-1:0] w_wr_onehot;
    logic [NREG-1:0] w_fwd_mask;
    logic [NREG-1:0] w_ebusy;
    logic            w_wr_en;
    logic            w_set_en;

    assign w_wr_en     = RegWrite && (RD != '0);
    assign w_wr_onehot = w_wr_en ? (NREG'(1) << RD) : '0;
    assign w_fwd_mask  = BYPASS ? w_wr_onehot : '0;

    // A register being written back this cycle is no longer a hazard when forwarding is on.
    assign w_ebusy = r_busy & ~w_fwd_mask;

    assign Stall = IssueValid &
                   (w_ebusy[RS1] | w_ebusy[RS2] | (IssueUsesRD & w_ebusy[IssueRD]));
    assign IssueReady = IssueValid & ~Stall;
    assign w_set_en   = IssueReady & IssueUsesRD & (IssueRD != '0);
    assign Busy       = r_busy;

    always_comb begin
        ReadData1 = r_regs[RS1];
        if (RS1 == '0) begin
            ReadData1 = '0;
        end else if (BYPASS && w_wr_en && (RD == RS1)) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = r_regs[RS2];
        if (RS2 == '0) begin
            ReadData2 = '0;
        end else if (BYPASS && w_wr_en && (RD == RS2)) begin
            ReadData2 = WriteData;
        end
    end

    // Set is applied after clear so a new producer keeps the bit pending.
    always_comb begin
        w_busy_d = r_busy & ~w_wr_onehot;
        if (w_set_en) begin
            w_busy_d[IssueRD] = 1'b1;
        end
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[RD] <= WriteData;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one forwarding and one non-forwarding instance share stimulus;
// expected values are hand-computed for each.
module tb_regfile_scoreboard;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1, rs2, rd, ird;
    logic [XLEN-1:0] wdata;
    logic            regwrite, ivalid, iuses;

    logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic            rdy_b, stall_b, rdy_n, stall_n;
    logic [NREG-1:0] busy_b, busy_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .RS1(rs1), .RS2(rs2),
        .ReadData1(rd1_b), .ReadData2(rd2_b),
        .RD(rd), .WriteData(wdata), .RegWrite(regwrite),
        .IssueValid(ivalid), .IssueRD(ird), .IssueUsesRD(iuses),
        .IssueReady(rdy_b), .Stall(stall_b), .Busy(busy_b)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1'b0)) u_dut_n (
        .clk(clk), .reset(reset), .RS1(rs1), .RS2(rs2),
        .ReadData1(rd1_n), .ReadData2(rd2_n),
        .RD(rd), .WriteData(wdata), .RegWrite(regwrite),
        .IssueValid(ivalid), .IssueRD(ird), .IssueUsesRD(iuses),
        .IssueReady(rdy_n), .Stall(stall_n), .Busy(busy_n)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        reset = 1'b0; rs1 = '0; rs2 = '0; rd = '0; wdata = '0;
        regwrite = 1'b0; ivalid = 1'b0; ird = '0; iuses = 1'b0;
    endtask

    initial begin
        idle();
        // Reset overrides a simultaneous write.
        reset = 1'b1; regwrite = 1'b1; rd = 5'd3; wdata = 64'hFF;
        tick();
        idle();
        rs1 = 5'd3; ivalid = 1'b1;
        settle();
        check_eq("rst_rd1_b", rd1_b, 64'h0);
        check_eq("rst_rd1_n", rd1_n, 64'h0);
        check_eq("rst_busy_b", {32'h0, busy_b}, 64'h0);
        check_eq("rst_busy_n", {32'h0, busy_n}, 64'h0);
        check_eq("rst_stall_b", {63'h0, stall_b}, 64'h0);
        check_eq("rst_rdy_b", {63'h0, rdy_b}, 64'h1);

        // Write latency and bypass.
        idle();
        regwrite = 1'b1; rd = 5'd1; wdata = 64'h1111; rs1 = 5'd1; rs2 = 5'd1;
        settle();
        check_eq("byp_rd1_b", rd1_b, 64'h1111);
        check_eq("byp_rd2_b", rd2_b, 64'h1111);
        check_eq("nobyp_rd1_n", rd1_n, 64'h0);
        check_eq("nobyp_rd2_n", rd2_n, 64'h0);
        tick();
        regwrite = 1'b0;
        settle();
        check_eq("lat_rd1_n", rd1_n, 64'h1111);
        check_eq("lat_rd2_n", rd2_n, 64'h1111);
        check_eq("wr_nonbusy_b", {32'h0, busy_b}, 64'h0);

        // Register 0 is hardwired.
        idle();
        regwrite = 1'b1; rd = 5'd0; wdata = 64'hDEAD;
        settle();
        check_eq("r0_byp_b", rd1_b, 64'h0);
        tick();
        regwrite = 1'b0;
        settle();
        check_eq("r0_rd_b", rd1_b, 64'h0);
        check_eq("r0_rd_n", rd1_n, 64'h0);
        ivalid = 1'b1; iuses = 1'b1; ird = 5'd0;
        settle();
        check_eq("r0_rdy_b", {63'h0, rdy_b}, 64'h1);
        check_eq("r0_rdy_n", {63'h0, rdy_n}, 64'h1);
        tick();
        ivalid = 1'b0;
        settle();
        check_eq("r0_busy_b", {32'h0, busy_b}, 64'h0);
        check_eq("r0_busy_n", {32'h0, busy_n}, 64'h0);

        // RAW stall and release.
        idle();
        ivalid = 1'b1; iuses = 1'b1; ird = 5'd5;
        tick();
        iuses = 1'b0; ird = '0; rs2 = 5'd5;
        settle();
        check_eq("raw_busy_b", {32'h0, busy_b}, 64'h20);
        check_eq("raw_busy_n", {32'h0, busy_n}, 64'h20);
        check_eq("raw_stall_b", {63'h0, stall_b}, 64'h1);
        check_eq("raw_rdy_b", {63'h0, rdy_b}, 64'h0);
        check_eq("raw_stall_n", {63'h0, stall_n}, 64'h1);
        regwrite = 1'b1; rd = 5'd5; wdata = 64'h42;
        settle();
        check_eq("raw_wb_stall_b", {63'h0, stall_b}, 64'h0);
        check_eq("raw_wb_rdy_b", {63'h0, rdy_b}, 64'h1);
        check_eq("raw_wb_rd2_b", rd2_b, 64'h42);
        check_eq("raw_wb_stall_n", {63'h0, stall_n}, 64'h1);
        check_eq("raw_wb_rdy_n", {63'h0, rdy_n}, 64'h0);
        check_eq("raw_wb_rd2_n", rd2_n, 64'h0);
        tick();
        regwrite = 1'b0;
        settle();
        check_eq("raw_rel_stall_n", {63'h0, stall_n}, 64'h0);
        check_eq("raw_rel_rdy_n", {63'h0, rdy_n}, 64'h1);
        check_eq("raw_rel_rd2_n", rd2_n, 64'h42);
        check_eq("raw_rel_busy_b", {32'h0, busy_b}, 64'h0);
        check_eq("raw_rel_busy_n", {32'h0, busy_n}, 64'h0);

        // WAW hazard and simultaneous set/clear.
        idle();
        ivalid = 1'b1; iuses = 1'b1; ird = 5'd7;
        tick();
        settle();
        check_eq("waw_busy_b", {32'h0, busy_b}, 64'h80);
        check_eq("waw_stall_b", {63'h0, stall_b}, 64'h1);
        check_eq("waw_rdy_b", {63'h0, rdy_b}, 64'h0);
        check_eq("waw_stall_n", {63'h0, stall_n}, 64'h1);
        regwrite = 1'b1; rd = 5'd7; wdata = 64'h77;
        settle();
        check_eq("waw_wb_rdy_b", {63'h0, rdy_b}, 64'h1);
        check_eq("waw_wb_stall_n", {63'h0, stall_n}, 64'h1);
        tick();
        idle();
        rs1 = 5'd7;
        settle();
        check_eq("waw_keep_busy_b", {32'h0, busy_b}, 64'h80);
        check_eq("waw_clr_busy_n", {32'h0, busy_n}, 64'h0);
        check_eq("waw_rd1_b", rd1_b, 64'h77);
        check_eq("waw_rd1_n", rd1_n, 64'h77);

        // Reset mid-operation drops pending busy bits; reset also overrides an issue.
        idle();
        ivalid = 1'b1; iuses = 1'b1; ird = 5'd2;
        tick();
        ird = 5'd9;
        tick();
        ivalid = 1'b0; iuses = 1'b0;
        settle();
        check_eq("mid_busy_b", {32'h0, busy_b}, 64'h284);
        check_eq("mid_busy_n", {32'h0, busy_n}, 64'h204);
        reset = 1'b1; ivalid = 1'b1; iuses = 1'b1; ird = 5'd3;
        tick();
        idle();
        rs1 = 5'd7; rs2 = 5'd1;
        settle();
        check_eq("mid_rst_busy_b", {32'h0, busy_b}, 64'h0);
        check_eq("mid_rst_busy_n", {32'h0, busy_n}, 64'h0);
        check_eq("mid_rst_rd1_b", rd1_b, 64'h0);
        check_eq("mid_rst_rd2_n", rd2_n, 64'h0);
        regwrite = 1'b1; rd = 5'd9; wdata = 64'h7;
        tick();
        idle();
        rs1 = 5'd9;
        settle();
        check_eq("post_rst_rd1_b", rd1_b, 64'h7);
        check_eq("post_rst_rd1_n", rd1_n, 64'h7);
        check_eq("post_rst_busy_b", {32'h0, busy_b}, 64'h0);
        check_eq("post_rst_busy_n", {32'h0, busy_n}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
